bloom_hash_gen: RTL
===================

# bloom_hash_gen

Byte-stream hashing front end of the bloom filter. It accepts one string at a time as a packetised byte stream and runs HASH_CNT independent CRC-16 (poly 0x8D95) lanes in parallel. Each lane is seeded from its own `CRC_INITS` entry. At end of string it presents HASH_CNT truncated hash indices, registered, to the bloom-filter memory stage downstream.

## Interface
- HASH_CNT, 4, number of parallel hash lanes; legal 1..20; elaboration error outside range.
- HASH_W, 10, index width per lane; legal 1..`MAX_HASH_W` (16); elaboration error outside range.
- LEN_W, 8, string-length counter width; used only with `BLOOM_HASH_LEN_EN`.
- clk_i  in  1  single clock; all state on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- snk_data_i  in  8  string byte.
- snk_valid_i  in  1  byte valid.
- snk_startofpacket_i  in  1  first byte of string.
- snk_endofpacket_i  in  1  last byte of string.
- snk_ready_o  out  1  byte accepted when valid & ready.
- src_hash_o  out  HASH_CNT*HASH_W  lane k at bits [k*HASH_W +: HASH_W].
- src_valid_o  out  1  hash vector valid.
- src_ready_i  in  1  downstream accepts hash vector.
- sop_err_o  out  1  one-cycle pulse: sop seen mid-string.
- src_len_o  out  LEN_W  byte count of string; present only with `BLOOM_HASH_LEN_EN`.

## Operation
- FSM states IDLE (no string open) and ACCUM (string open). Separate output register: out_valid plus hash vector.
- Accepted byte in IDLE, or any accepted byte with sop=1: every lane computes crc_r[k] <= crc_8d95(data, CRC_INITS[k]). A byte without sop in IDLE starts a string.
- Accepted byte in ACCUM without sop: crc_r[k] <= crc_8d95(data, crc_r[k]).
- Accepted byte with sop in ACCUM: discard the partial string and restart from the seeds, as above. sop_err_o pulses for 1 cycle. State stays ACCUM, or goes to IDLE if eop is also set.
- Accepted byte with eop: load the output register with the low HASH_W bits of each lane's next CRC value. Set out_valid and go to IDLE. sop&eop on the same byte forms a 1-byte string.
- snk_ready_o = !out_valid | src_ready_i. This is combinational and gives zero-bubble back-to-back strings.
- out_valid clears on src_valid_o & src_ready_i, unless a new eop is accepted in the same cycle. In that case the register reloads and out_valid stays 1.
- Downstream backpressure holds src_hash_o stable. Input stalls only while out_valid=1 & src_ready_i=0.

## Timing
- Reset values: snk_ready_o=1, src_valid_o=0, src_hash_o=0, sop_err_o=0, src_len_o=0. Internal state: IDLE, crc_r=0.
- Latency: eop byte accepted in cycle N gives src_valid_o=1 in cycle N+1.
- Throughput: 1 byte/cycle sustained, including across string boundaries.
- Reset asserted mid-string: the partial string and any pending hash are lost. No output appears after release.
- snk_valid_i=0 cycles inside a string are legal and leave state unchanged.

## Configuration
- `BLOOM_HASH_LEN_EN` defined:
  - A LEN_W counter loads 1 on a string-start byte and increments on other accepted bytes, saturating at 2^LEN_W-1.
  - The count is latched with the hash into src_len_o.
- `BLOOM_HASH_LEN_EN` undefined: src_len_o and the counter do not exist.

## Structure
- `crc_pkg` holds `crc_8d95`, `CRC_INITS` and `MAX_HASH_W`.
- Add to `crc_pkg`:
  - state enum `bloom_hash_state_t` (IDLE, ACCUM);
  - `BLOOM_MAX_HASH_CNT` = 20 for the HASH_CNT range check.
- Sub-module `bloom_hash_lane`: one CRC register plus seed mux, parameter SEED, HASH_W-bit output. The top instantiates it with a generate loop over HASH_CNT.

## Test plan
- Defaults; 1-byte string 0x00 (sop&eop) -> next cycle src_valid_o=1; lanes 0..3 = 0x100, 0x200, 0x300, 0x000.
- String 0x00,0x00 -> lane 0 = 0x195 (full CRC 0x8D95); string 0x01 -> lane 0 = 0x095.
- Back-to-back strings, src_ready_i=1 -> snk_ready_o stays 1; one src_valid_o cycle per string, correct hashes.
- src_ready_i=0 for 5 cycles with hash pending -> src_hash_o stable, snk_ready_o=0, no byte lost; resumes on ready.
- Mid-string sop: 0xAA, then 0x00 with sop&eop -> sop_err_o pulses once; lane 0 = 0x100.
- rst_n_i pulsed mid-string, then 0x00 sop&eop -> lane 0 = 0x100. With `BLOOM_HASH_LEN_EN`: src_len_o=1; a 300-byte string gives src_len_o=255.

Source files
------------

// File: rtl/crc_pkg.sv
// -----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the bloom-filter hashing front end:
//   - crc_8d95()          : one-byte update of a CRC-16, polynomial 0x8D95,
//                           MSB first, no reflection, no final XOR
//   - CRC_INITS[]         : per-lane seed values (one per possible hash lane)
//   - MAX_HASH_W          : widest legal truncated hash index
//   - BLOOM_MAX_HASH_CNT  : largest legal number of hash lanes
//   - bloom_hash_state_t  : string-framing state of bloom_hash_gen
// -----------------------------------------------------------------------------
package crc_pkg;

    localparam int MAX_HASH_W         = 16;
    localparam int BLOOM_MAX_HASH_CNT = 20;

    localparam logic [15:0] CRC_POLY = 16'h8D95;

    // Lane seeds. The first four have a zero high byte, so a single 0x00 byte
    // moves the seed's low byte straight into the high byte of the CRC; this
    // keeps hand-computed hashes for short strings easy to derive.
    localparam logic [15:0] CRC_INITS [BLOOM_MAX_HASH_CNT] = '{
        16'h0001, 16'h0002, 16'h0003, 16'h0004,
        16'hFFFF, 16'h1D0F, 16'hA5A5, 16'h5A5A,
        16'h1234, 16'h4321, 16'hBEEF, 16'hCAFE,
        16'h0F0F, 16'hF0F0, 16'h3C3C, 16'hC3C3,
        16'h7E7E, 16'h8181, 16'h55AA, 16'hAA55
    };

    typedef enum logic [0:0] {
        IDLE  = 1'b0,   // no string open
        ACCUM = 1'b1    // string open, lanes hold a partial CRC
    } bloom_hash_state_t;

    // Byte-wide CRC update: fold the byte into the high end, then run eight
    // shift/reduce steps.
    function automatic logic [15:0] crc_8d95(input logic [7:0]  data,
                                             input logic [15:0] crc);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/bloom_hash_lane.sv
// -----------------------------------------------------------------------------
// bloom_hash_lane
// One CRC-16 (0x8D95) lane: a 16-bit CRC register with a seed mux in front of
// the byte update. Exposes the truncated CRC *after* the current byte so the
// top can capture the final hash in the same cycle as the eop byte.
//
// Parameters
//   SEED    : CRC value a string starts from
//   HASH_W  : width of the truncated hash output
// Ports
//   i_clk        : clock, rising edge
//   i_rst_n      : asynchronous active-low reset (CRC register -> 0)
//   i_byte_en    : a byte is accepted this cycle
//   i_restart    : this byte starts a string (update from SEED, not the register)
//   i_data       : the byte
//   o_hash_next  : low HASH_W bits of the CRC including i_data
// -----------------------------------------------------------------------------
module bloom_hash_lane
    import crc_pkg::*;
#(
    parameter logic [15:0] SEED   = 16'h0000,
    parameter int          HASH_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_byte_en,
    input  logic              i_restart,
    input  logic [7:0]        i_data,
    output logic [HASH_W-1:0] o_hash_next
);

    logic [15:0] r_crc;
    logic [15:0] w_crc_base;
    logic [15:0] w_crc_next;

    assign w_crc_base  = i_restart ? SEED : r_crc;
    assign w_crc_next  = crc_8d95(i_data, w_crc_base);
    assign o_hash_next = w_crc_next[HASH_W-1:0];

    // NOTE: sequential state is written with <= only, so every register in the
    // design samples values from before the edge regardless of block order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_crc <= '0;
        end else if (i_byte_en) begin
            r_crc <= w_crc_next;
        end
    end

    // Upper CRC bits are deliberately dropped by the truncation.
    if (HASH_W < 16) begin : g_trunc
        logic w_unused_bits;
        assign w_unused_bits = ^w_crc_next[15:HASH_W];
    end

endmodule

// File: rtl/bloom_hash_gen.sv
// -----------------------------------------------------------------------------
// bloom_hash_gen
// Byte-stream hashing front end of the bloom filter. Accepts one string at a
// time as a packetised byte stream, runs HASH_CNT CRC-16 (0x8D95) lanes in
// parallel (lane k seeded from CRC_INITS[k]) and at end of string presents the
// HASH_CNT truncated indices in a registered output stage.
//
// Optional feature macro: BLOOM_HASH_LEN_EN
//   defined   -> a saturating LEN_W byte counter is latched with the hash and
//                presented on src_len_o
//   undefined -> no counter, no src_len_o port
//
// Parameters
//   HASH_CNT : number of hash lanes, 1..BLOOM_MAX_HASH_CNT
//   HASH_W   : index width per lane, 1..MAX_HASH_W
//   LEN_W    : length counter width (used with BLOOM_HASH_LEN_EN only)
// Ports
//   clk_i, rst_n_i            : clock (rising edge), async active-low reset
//   snk_data_i/valid/sop/eop  : input byte stream
//   snk_ready_o               : byte accepted when valid & ready
//   src_hash_o                : lane k at [k*HASH_W +: HASH_W]
//   src_valid_o, src_ready_i  : output handshake
//   sop_err_o                 : one-cycle pulse after a sop arrives mid-string
//   src_len_o                 : string byte count (BLOOM_HASH_LEN_EN only)
// -----------------------------------------------------------------------------
module bloom_hash_gen
    import crc_pkg::*;
#(
    parameter int HASH_CNT = 4,
    parameter int HASH_W   = 10,
    parameter int LEN_W    = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [7:0]                 snk_data_i,
    input  logic                       snk_valid_i,
    input  logic                       snk_startofpacket_i,
    input  logic                       snk_endofpacket_i,
    output logic                       snk_ready_o,
    output logic [HASH_CNT*HASH_W-1:0] src_hash_o,
    output logic                       src_valid_o,
    input  logic                       src_ready_i,
    output logic                       sop_err_o
`ifdef BLOOM_HASH_LEN_EN
    ,
    output logic [LEN_W-1:0]           src_len_o
`endif
);

    // ---------------------------------------------------------------- checks
    if (HASH_CNT < 1 || HASH_CNT > BLOOM_MAX_HASH_CNT) begin : g_bad_hash_cnt
        $error("bloom_hash_gen: HASH_CNT=%0d outside 1..%0d", HASH_CNT, BLOOM_MAX_HASH_CNT);
    end
    if (HASH_W < 1 || HASH_W > MAX_HASH_W) begin : g_bad_hash_w
        $error("bloom_hash_gen: HASH_W=%0d outside 1..%0d", HASH_W, MAX_HASH_W);
    end
    if (LEN_W < 1) begin : g_bad_len_w
        $error("bloom_hash_gen: LEN_W=%0d must be at least 1", LEN_W);
    end

    // ---------------------------------------------------------------- control
    bloom_hash_state_t           r_state;
    logic                        r_out_valid;
    logic [HASH_CNT*HASH_W-1:0]  r_out_hash;
    logic                        r_sop_err;

    logic                        w_accept;
    logic                        w_restart;
    logic                        w_load;
    logic                        w_sop_mid;
    logic [HASH_CNT*HASH_W-1:0]  w_hash_next;

    // Combinational ready lets a new eop be taken in the very cycle the
    // previous hash is handed off, so strings stream without bubbles.
    assign snk_ready_o = !r_out_valid || src_ready_i;
    assign w_accept    = snk_valid_i && snk_ready_o;
    // A string starts on any byte taken in IDLE, and restarts on any sop.
    assign w_restart   = (r_state == IDLE) || snk_startofpacket_i;
    assign w_load      = w_accept && snk_endofpacket_i;
    assign w_sop_mid   = w_accept && snk_startofpacket_i && (r_state == ACCUM);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else if (w_accept) begin
            r_state <= snk_endofpacket_i ? IDLE : ACCUM;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sop_err <= 1'b0;
        end else begin
            r_sop_err <= w_sop_mid;
        end
    end

    // ---------------------------------------------------------------- lanes
    for (genvar k = 0; k < HASH_CNT; k++) begin : g_lane
        bloom_hash_lane #(
            .SEED   (CRC_INITS[k]),
            .HASH_W (HASH_W)
        ) u_lane (
            .i_clk       (clk_i),
            .i_rst_n     (rst_n_i),
            .i_byte_en   (w_accept),
            .i_restart   (w_restart),
            .i_data      (snk_data_i),
            .o_hash_next (w_hash_next[k*HASH_W +: HASH_W])
        );
    end

    // ---------------------------------------------------------------- output
    // A reload in the hand-off cycle wins over the clear, keeping valid high.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_out_valid <= 1'b0;
            r_out_hash  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_hash  <= w_hash_next;
        end else if (src_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign src_valid_o = r_out_valid;
    assign src_hash_o  = r_out_hash;
    assign sop_err_o   = r_sop_err;

`ifdef BLOOM_HASH_LEN_EN
    // ---------------------------------------------------------------- length
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_out_len;
    logic [LEN_W-1:0] w_len_next;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block can leave it holding state (no latch).
    always_comb begin
        w_len_next = r_len;
        if (w_restart) begin
            w_len_next = LEN_W'(1);
        end else if (r_len != '1) begin
            w_len_next = r_len + LEN_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_len     <= '0;
            r_out_len <= '0;
        end else begin
            if (w_accept) begin
                r_len <= w_len_next;
            end
            if (w_load) begin
                r_out_len <= w_len_next;
            end
        end
    end

    assign src_len_o = r_out_len;
`else
    logic [LEN_W-1:0] w_len_unused;
    assign w_len_unused = '0;
`endif

endmodule
